vram_arbiter: RTL and testbench
===============================

// Module: vram_arbiter
// PURPOSE
//  Shares one single-port synchronous video RAM between two requesters: the CPU data-memory port (load/store) and the VGA scan-out reader.
//  Grants at most one access per cycle and stalls the loser.
//  Returns read data one cycle after grant, tagged to the winning requester.
//  Sits in sopc between the CPU's memory stage, the VGA controller and the VRAM macro.
// PARAMETERS
//  ADDR_W        15  VRAM word address width
//  DATA_W        8   VRAM data width (one byte, matches `BYTEWIDTH)
// PORTS
//  CLOCK_50    in   1       system clock, all state on rising edge
//  rst         in   1       reset, asynchronous, active-high (`RSTENABLE)
//  cpu_req     in   1       CPU access request
//  cpu_we      in   1       1 = write, 0 = read
//  cpu_addr    in   ADDR_W  CPU address
//  cpu_wdata   in   DATA_W  CPU write data
//  cpu_stall   out  1       CPU request present but not granted this cycle
//  cpu_ack     out  1       one-cycle pulse: CPU access completed (read data valid)
//  cpu_rdata   out  DATA_W  CPU read data, held until next CPU read return
//  vga_req     in   1       VGA read request
//  vga_addr    in   ADDR_W  VGA read address
//  vga_valid   out  1       one-cycle pulse: vga_q carries new data
//  vga_q       out  DATA_W  VGA read data, held until next VGA return
//  ram_addr    out  ADDR_W  to VRAM
//  ram_we      out  1       to VRAM
//  ram_wdata   out  DATA_W  to VRAM
//  ram_q       in   DATA_W  from VRAM, registered read (valid cycle after address)
// BEHAVIOUR
//  - Grant decided combinationally each cycle from current requests and registered last_winner.
//  - ram_addr/ram_we/ram_wdata are muxed from the winner. With no winner: ram_we=0 and ram_addr holds its last value.
//  - cpu_stall = cpu_req & ~cpu_grant. It is combinational, so the CPU freezes its pipeline the same cycle.
//  - Requesters keep req/addr/we/wdata stable while not granted.
//  - Owner pipeline: register owner tag {NONE,CPU,VGA} at grant (cycle N).
//  - At N+1, tag CPU gives cpu_ack=1; if the access was a read, cpu_rdata<=ram_q.
//  - At N+1, tag VGA gives vga_valid=1 and vga_q<=ram_q.
//  - Latency is exactly 1 cycle. Throughput is 1 access/cycle; back-to-back grants to either side are allowed.
//  - A CPU write is granted and acked like a read; cpu_rdata is unchanged by a write.
//  - Only one requester: it is granted every cycle it requests (no bubbles).
//  - Conflict (both req same cycle): the winner is chosen per CONFIGURATION. The loser is granted on the next cycle it still requests and the other side is idle, or by the fairness rule.
//  - CPU write and VGA read to the same address: the accesses are strictly serialized in grant order. VGA sees new data only if the write was granted first.
//  - last_winner updates only on conflict cycles.
//  - Reset (any cycle, async):
//    - owner tag <= NONE, and in-flight returns are dropped.
//    - cpu_ack=0, vga_valid=0, cpu_rdata=0, vga_q=0.
//    - ram_we=0, ram_addr=0, ram_wdata=0, last_winner<=CPU.
//    - cpu_stall during reset = 0.
// CONFIGURATION
//  VRAM_ARB_FAIR_EN defined:
//    - Round-robin on conflict: the side that lost the previous conflict wins.
//    - Neither side is denied two consecutive conflicts.
//  VRAM_ARB_FAIR_EN undefined:
//    - Fixed priority: VGA always wins conflicts (display is real-time).
//    - The CPU stalls for as long as vga_req is held.
// STRUCTURE
//  - Shared macro.v: `VRAM_ADDRWIDTH, owner encodings `OWN_NONE/`OWN_CPU/`OWN_VGA (2 bits).
//  - Reuse `BYTEWIDTH and `RSTENABLE/`RSTDISABLE from macro.v.
//  - One sub-module, vram_arb_pick: combinational grant logic, (cpu_req, vga_req, last_winner) -> (cpu_grant, vga_grant, conflict).
//  - vram_arb_pick holds the VRAM_ARB_FAIR_EN ifdef.
//  - Owner pipeline, data capture and ram mux live in vram_arbiter.
// TESTING
//  - CPU-only reads at addr 0x0010,0x0011 back-to-back:
//    - cpu_stall=0 throughout.
//    - cpu_ack on cycles N+1,N+2.
//    - cpu_rdata = preloaded 0xA5,0x5A.
//  - CPU write 0x3C to 0x0100, then CPU read 0x0100 next cycle: second ack returns cpu_rdata=0x3C. vga_valid never pulses.
//  - Both request every cycle for 6 cycles, fair build:
//    - Grants alternate VGA,CPU,VGA,... (first conflict goes to VGA, since last_winner resets to CPU).
//    - cpu_stall toggles.
//    - 3 acks and 3 valids.
//  - Same stimulus, non-fair build: 6 vga_valid, 0 cpu_ack, cpu_stall=1 all 6 cycles. cpu_ack comes 1 cycle after vga_req drops.
//  - Same-cycle CPU write 0xFF to 0x0200 and VGA read 0x0200 (old 0x00), fair build, after a VGA conflict win: CPU granted first, then the VGA read returns vga_q=0xFF.
//  - Assert rst the cycle after a CPU read grant: no cpu_ack, cpu_rdata=0, ram_we=0. After release, the first request is granted the same cycle.

Source files
------------

// File: rtl/vram_arbiter_pkg.sv
// Shared constants for the VRAM arbiter: bus widths, reset levels and owner-tag encodings.
package vram_arbiter_pkg;

    localparam int unsigned BYTEWIDTH      = 8;
    localparam int unsigned VRAM_ADDRWIDTH = 15;

    localparam logic RSTENABLE  = 1'b1;
    localparam logic RSTDISABLE = 1'b0;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_VGA  = 2'd2;

    localparam logic LAST_CPU = 1'b0;
    localparam logic LAST_VGA = 1'b1;

    function automatic logic [1:0] owner_of(input logic cpu_g, input logic vga_g);
        if (vga_g)      return OWN_VGA;
        else if (cpu_g) return OWN_CPU;
        else            return OWN_NONE;
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of CPU, VGA and VRAM-macro signals around the arbiter; slave = arbiter side.
interface vram_arbiter_if
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDRWIDTH,
    parameter int unsigned DATA_W = BYTEWIDTH
) ();

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_valid;
    logic [DATA_W-1:0] vga_q;

    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, ram_q,
        output cpu_stall, cpu_ack, cpu_rdata, vga_valid, vga_q,
               ram_addr, ram_we, ram_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vga_req, vga_addr, ram_q,
        input  cpu_stall, cpu_ack, cpu_rdata, vga_valid, vga_q,
               ram_addr, ram_we, ram_wdata
    );

endinterface

// File: rtl/vram_arb_pick.sv
// Combinational grant selection between CPU and VGA.
// `define VRAM_ARB_FAIR_EN for round-robin on conflict; otherwise VGA has fixed priority.
module vram_arb_pick
    import vram_arbiter_pkg::*;
(
    input  logic cpu_req_i,
    input  logic vga_req_i,
    input  logic last_winner_i,
    output logic cpu_grant_o,
    output logic vga_grant_o,
    output logic conflict_o
);

    assign conflict_o = cpu_req_i & vga_req_i;

`ifdef VRAM_ARB_FAIR_EN
    // On conflict the side that lost the previous conflict wins.
    assign vga_grant_o = vga_req_i & (~cpu_req_i | (last_winner_i == LAST_CPU));
`else
    logic unused_last_winner;
    assign unused_last_winner = last_winner_i;
    assign vga_grant_o = vga_req_i;
`endif

    assign cpu_grant_o = cpu_req_i & ~vga_grant_o;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between the CPU memory stage and the VGA scan-out reader.
// Grant policy lives in vram_arb_pick (VRAM_ARB_FAIR_EN selects round-robin).
module vram_arbiter
    import vram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = VRAM_ADDRWIDTH,
    parameter int unsigned DATA_W = BYTEWIDTH
) (
    input  logic           CLOCK_50,
    input  logic           rst,
    vram_arbiter_if.slave  bus
);

    logic              active;
    logic              cpu_grant;
    logic              vga_grant;
    logic              conflict;

    logic [1:0]        owner_q;
    logic              cpu_rd_q;
    logic              last_winner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] vga_q_q;

    logic [ADDR_W-1:0] ram_addr_d;
    logic              ram_we_d;
    logic [DATA_W-1:0] ram_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_d;
    logic [DATA_W-1:0] vga_q_d;

    assign active = (rst == RSTDISABLE);

    vram_arb_pick u_pick (
        .cpu_req_i     (bus.cpu_req & active),
        .vga_req_i     (bus.vga_req & active),
        .last_winner_i (last_winner_q),
        .cpu_grant_o   (cpu_grant),
        .vga_grant_o   (vga_grant),
        .conflict_o    (conflict)
    );

    assign bus.cpu_stall = bus.cpu_req & ~cpu_grant & active;

    always_comb begin
        ram_addr_d  = addr_q;
        ram_we_d    = 1'b0;
        ram_wdata_d = wdata_q;
        if (cpu_grant) begin
            ram_addr_d  = bus.cpu_addr;
            ram_we_d    = bus.cpu_we;
            ram_wdata_d = bus.cpu_wdata;
        end else if (vga_grant) begin
            ram_addr_d  = bus.vga_addr;
        end
    end

    assign bus.ram_addr  = ram_addr_d;
    assign bus.ram_we    = ram_we_d;
    assign bus.ram_wdata = ram_wdata_d;

    assign bus.cpu_ack   = (owner_q == OWN_CPU);
    assign bus.vga_valid = (owner_q == OWN_VGA);

    // Return data bypasses the holding register so it is valid in the same cycle as ack/valid.
    assign cpu_rdata_d   = (bus.cpu_ack && cpu_rd_q) ? bus.ram_q : cpu_rdata_q;
    assign vga_q_d       = bus.vga_valid ? bus.ram_q : vga_q_q;
    assign bus.cpu_rdata = cpu_rdata_d;
    assign bus.vga_q     = vga_q_d;

    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst == RSTENABLE) begin
            owner_q       <= OWN_NONE;
            cpu_rd_q      <= 1'b0;
            last_winner_q <= LAST_CPU;
            addr_q        <= '0;
            wdata_q       <= '0;
            cpu_rdata_q   <= '0;
            vga_q_q       <= '0;
        end else begin
            owner_q     <= owner_of(cpu_grant, vga_grant);
            cpu_rd_q    <= ~bus.cpu_we;
            addr_q      <= ram_addr_d;
            wdata_q     <= ram_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            vga_q_q     <= vga_q_d;
            if (conflict) begin
                last_winner_q <= vga_grant ? LAST_VGA : LAST_CPU;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: vector table for single-requester traffic, hand sequences for conflicts and reset.
module tb_vram_arbiter;
    import vram_arbiter_pkg::*;

    localparam int unsigned AW = 15;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLOCK_50 (clk),
        .rst      (rst),
        .bus      (bus)
    );

    // Registered-read RAM model with a bench-only preload port
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_we = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [DW-1:0] pl_data = '0;

    always @(posedge clk) begin
        if (pl_we)           mem[pl_addr] <= pl_data;
        else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_q <= mem[bus.ram_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic creq, input logic cwe, input logic [AW-1:0] caddr,
                         input logic [DW-1:0] cwd, input logic vreq, input logic [AW-1:0] vaddr);
        bus.cpu_req   = creq;
        bus.cpu_we    = cwe;
        bus.cpu_addr  = caddr;
        bus.cpu_wdata = cwd;
        bus.vga_req   = vreq;
        bus.vga_addr  = vaddr;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          creq, cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          vreq;
        logic [AW-1:0] vaddr;
        logic          stall, ack, valid;
        logic [DW-1:0] rdata, vq;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } vec_t;

    function automatic vec_t mk(
        input logic creq, input logic cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
        input logic vreq, input logic [AW-1:0] vaddr,
        input logic stall, input logic ack, input logic valid,
        input logic [DW-1:0] rdata, input logic [DW-1:0] vq,
        input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        vec_t v;
        v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
        v.vreq = vreq; v.vaddr = vaddr;
        v.stall = stall; v.ack = ack; v.valid = valid;
        v.rdata = rdata; v.vq = vq; v.we = we; v.addr = addr; v.wdata = wdata;
        return v;
    endfunction

    vec_t vecs [10];
    int   acks;
    int   valids;

    initial begin
        // Each row: inputs for this cycle; ack/valid/data reflect the previous row's grant
        vecs[0] = mk(0,0,15'h000,8'h00, 0,15'h000,  0,0,0, 8'h00,8'h00, 0,15'h000,8'h00);
        vecs[1] = mk(1,0,15'h010,8'h00, 0,15'h000,  0,0,0, 8'h00,8'h00, 0,15'h010,8'h00);
        vecs[2] = mk(1,0,15'h011,8'h00, 0,15'h000,  0,1,0, 8'hA5,8'h00, 0,15'h011,8'h00);
        vecs[3] = mk(1,1,15'h100,8'h3C, 0,15'h000,  0,1,0, 8'h5A,8'h00, 1,15'h100,8'h3C);
        vecs[4] = mk(1,0,15'h100,8'h00, 0,15'h000,  0,1,0, 8'h5A,8'h00, 0,15'h100,8'h00);
        vecs[5] = mk(0,0,15'h000,8'h00, 0,15'h000,  0,1,0, 8'h3C,8'h00, 0,15'h100,8'h00);
        vecs[6] = mk(0,0,15'h000,8'h00, 1,15'h300,  0,0,0, 8'h3C,8'h00, 0,15'h300,8'h00);
        vecs[7] = mk(0,0,15'h000,8'h00, 1,15'h301,  0,0,1, 8'h3C,8'h11, 0,15'h301,8'h00);
        vecs[8] = mk(0,0,15'h000,8'h00, 0,15'h000,  0,0,1, 8'h3C,8'h22, 0,15'h301,8'h00);
        vecs[9] = mk(0,0,15'h000,8'h00, 0,15'h000,  0,0,0, 8'h3C,8'h22, 0,15'h301,8'h00);

        rst = 1'b1;
        drive(0, 0, '0, '0, 0, '0);
        #1;

        pl_we = 1'b1;
        pl_addr = 15'h010; pl_data = 8'hA5; next_cycle();
        pl_addr = 15'h011; pl_data = 8'h5A; next_cycle();
        pl_addr = 15'h300; pl_data = 8'h11; next_cycle();
        pl_addr = 15'h301; pl_data = 8'h22; next_cycle();
        pl_addr = 15'h200; pl_data = 8'h00; next_cycle();
        pl_we = 1'b0;

        // Requests during reset must be ignored
        drive(1, 1, 15'h040, 8'h99, 1, 15'h050);
        #2;
        check("rst_stall", bus.cpu_stall, 0);
        check("rst_ram_we", bus.ram_we, 0);
        check("rst_ram_addr", bus.ram_addr, 0);
        check("rst_ram_wdata", bus.ram_wdata, 0);
        check("rst_ack", bus.cpu_ack, 0);
        check("rst_valid", bus.vga_valid, 0);
        check("rst_rdata", bus.cpu_rdata, 0);
        check("rst_vga_q", bus.vga_q, 0);
        drive(0, 0, '0, '0, 0, '0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].creq, vecs[i].cwe, vecs[i].caddr, vecs[i].cwd, vecs[i].vreq, vecs[i].vaddr);
            #2;
            check($sformatf("v%0d_stall", i), bus.cpu_stall, vecs[i].stall);
            check($sformatf("v%0d_ack", i),   bus.cpu_ack,   vecs[i].ack);
            check($sformatf("v%0d_valid", i), bus.vga_valid, vecs[i].valid);
            check($sformatf("v%0d_rdata", i), bus.cpu_rdata, vecs[i].rdata);
            check($sformatf("v%0d_vga_q", i), bus.vga_q,     vecs[i].vq);
            check($sformatf("v%0d_ram_we", i), bus.ram_we,   vecs[i].we);
            check($sformatf("v%0d_ram_addr", i), bus.ram_addr, vecs[i].addr);
            check($sformatf("v%0d_ram_wdata", i), bus.ram_wdata, vecs[i].wdata);
            next_cycle();
        end

        // Six cycles of simultaneous requests
        acks = 0;
        valids = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 15'h010, 8'h00, 1, 15'h300);
            #2;
`ifdef VRAM_ARB_FAIR_EN
            check($sformatf("conf%0d_stall", k), bus.cpu_stall, ((k % 2) == 0) ? 1 : 0);
`else
            check($sformatf("conf%0d_stall", k), bus.cpu_stall, 1);
`endif
            if (k > 0) begin
                acks   += int'(bus.cpu_ack);
                valids += int'(bus.vga_valid);
            end
            next_cycle();
        end
        drive(1, 0, 15'h010, 8'h00, 0, 15'h000);
        #2;
        check("conf_drop_stall", bus.cpu_stall, 0);
        check("conf_drop_vga_q", bus.vga_q, 8'h11);
        acks   += int'(bus.cpu_ack);
        valids += int'(bus.vga_valid);
`ifdef VRAM_ARB_FAIR_EN
        check("conf_ack_count", acks, 3);
        check("conf_valid_count", valids, 3);
`else
        check("conf_ack_count", acks, 0);
        check("conf_valid_count", valids, 6);
`endif
        next_cycle();
        drive(0, 0, '0, '0, 0, '0);
        #2;
        check("conf_tail_ack", bus.cpu_ack, 1);
        check("conf_tail_rdata", bus.cpu_rdata, 8'hA5);
        next_cycle();

        // CPU write and VGA read of the same address are serialized in grant order
        drive(1, 1, 15'h200, 8'hFF, 1, 15'h300);
        #2;
        check("ser0_stall", bus.cpu_stall, 1);
        check("ser0_ram_addr", bus.ram_addr, 15'h300);
        next_cycle();
`ifdef VRAM_ARB_FAIR_EN
        drive(1, 1, 15'h200, 8'hFF, 1, 15'h200);
        #2;
        check("ser1_stall", bus.cpu_stall, 0);
        check("ser1_ram_we", bus.ram_we, 1);
        check("ser1_ram_wdata", bus.ram_wdata, 8'hFF);
        check("ser1_vga_q", bus.vga_q, 8'h11);
        next_cycle();
        drive(0, 0, '0, '0, 1, 15'h200);
        #2;
        check("ser2_ack", bus.cpu_ack, 1);
        check("ser2_ram_we", bus.ram_we, 0);
        check("ser2_ram_addr", bus.ram_addr, 15'h200);
        next_cycle();
        drive(0, 0, '0, '0, 0, '0);
        #2;
        check("ser3_valid", bus.vga_valid, 1);
        check("ser3_vga_q", bus.vga_q, 8'hFF);
        next_cycle();
`else
        drive(1, 1, 15'h200, 8'hFF, 1, 15'h200);
        #2;
        check("ser1_stall", bus.cpu_stall, 1);
        check("ser1_ram_we", bus.ram_we, 0);
        check("ser1_ram_addr", bus.ram_addr, 15'h200);
        check("ser1_vga_q", bus.vga_q, 8'h11);
        next_cycle();
        drive(1, 1, 15'h200, 8'hFF, 0, 15'h000);
        #2;
        check("ser2_stall", bus.cpu_stall, 0);
        check("ser2_ram_we", bus.ram_we, 1);
        check("ser2_valid", bus.vga_valid, 1);
        check("ser2_vga_q_old", bus.vga_q, 8'h00);
        next_cycle();
        drive(0, 0, '0, '0, 0, '0);
        #2;
        check("ser3_ack", bus.cpu_ack, 1);
        check("ser3_valid", bus.vga_valid, 0);
        next_cycle();
        drive(0, 0, '0, '0, 1, 15'h200);
        #2;
        check("ser4_ram_addr", bus.ram_addr, 15'h200);
        next_cycle();
        drive(0, 0, '0, '0, 0, '0);
        #2;
        check("ser5_valid", bus.vga_valid, 1);
        check("ser5_vga_q", bus.vga_q, 8'hFF);
        next_cycle();
`endif

        // Reset right after a CPU read grant drops the return
        drive(1, 0, 15'h011, 8'h00, 0, 15'h000);
        #2;
        check("rr_grant_stall", bus.cpu_stall, 0);
        check("rr_grant_addr", bus.ram_addr, 15'h011);
        next_cycle();
        rst = 1'b1;
        drive(1, 1, 15'h050, 8'h77, 0, 15'h000);
        #2;
        check("rr_ack", bus.cpu_ack, 0);
        check("rr_rdata", bus.cpu_rdata, 0);
        check("rr_ram_we", bus.ram_we, 0);
        check("rr_ram_addr", bus.ram_addr, 0);
        check("rr_ram_wdata", bus.ram_wdata, 0);
        check("rr_stall", bus.cpu_stall, 0);
        next_cycle();
        rst = 1'b0;
        drive(1, 0, 15'h010, 8'h00, 0, 15'h000);
        #2;
        check("rel_stall", bus.cpu_stall, 0);
        check("rel_ram_addr", bus.ram_addr, 15'h010);
        check("rel_ack", bus.cpu_ack, 0);
        next_cycle();
        drive(0, 0, '0, '0, 0, '0);
        #2;
        check("rel_ack_next", bus.cpu_ack, 1);
        check("rel_rdata", bus.cpu_rdata, 8'hA5);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
